ps2_rx_fifo: RTL and testbench
==============================

// Module: ps2_rx_fifo
// PURPOSE
//  Parametrised PS/2 device-to-host receiver with input synchroniser, full 11-bit frame check
//  (start/parity/stop), inactivity timeout and FWFT receive FIFO. Sits between the PS/2 pins
//  and the CPU-facing keyboard port, and buffers scan-code bursts so the poll loop can lag.
// PARAMETERS
//  DEPTH      8    FIFO entries; power of 2, 2..64
//  TOUT       128  tim_clk ticks without a ps2_clock edge before a frame is aborted (~138us @925.9kHz)
//  SYNC       2    synchroniser flops on ps2_clock/ps2_data, 2..3
// PORTS
//  clk        in   1   system clock, 50 MHz
//  res        in   1   synchronous reset, active-high
//  clk0       in   1   sampling strobe; all PS/2 logic advances only when clk0=1
//  tim_clk    in   1   timeout tick, 1-clk pulse
//  ps2_clock  in   1   PS/2 CLOCK pin, asynchronous
//  ps2_data   in   1   PS/2 DATA pin, asynchronous
//  rd         in   1   pop head of FIFO (ignored when empty)
//  rd_data    out  8   FIFO head byte (valid while rx_valid=1)
//  rx_valid   out  1   FIFO not empty
//  rx_full    out  1   FIFO full
//  rx_level   out  $clog2(DEPTH)+1  entries in FIFO
//  err        out  4   sticky {overflow, timeout, frame, parity}
//  err_clr    in   1   clear all err bits
// BEHAVIOUR
//  Reset: rd_data=0, rx_valid=0, rx_full=0, rx_level=0, err=0, FSM=IDLE, sync chain=all 1s.
//  Sync: SYNC flops every clk; edge detect on last two sync values, updated only on clk0.
//  Bits sampled on ps2_clock falling edge (prev=1, cur=0 at a clk0 cycle).
//  FSM (transitions only on clk0 cycles):
//   IDLE   - fall edge: data=0 -> DATA, bitcnt=0; data=1 -> err.frame=1, stay IDLE.
//   DATA   - fall edge: shift data in LSB-first; after 8th bit -> PARITY.
//   PARITY - fall edge: capture bit -> STOP.
//   STOP   - fall edge: data=1 and ^{byte,par}=1 (odd) -> push byte; data=0 -> err.frame;
//            parity even -> err.parity; byte discarded on any error; always -> IDLE.
//  Timeout: counter cleared on any ps2_clock edge and in IDLE; +1 per tim_clk while not IDLE
//   (tim_clk counted regardless of clk0); reaching TOUT -> IDLE, partial byte dropped,
//   err.timeout=1.
//  Push: in the clk cycle of the stop-bit sample; rx_valid/rd_data update next clk.
//  FIFO: FWFT; rd with rx_valid=1 pops, new head visible next clk.
//   Push while full and no pop -> byte dropped, err.overflow=1, contents unchanged.
//   Push and pop same cycle: both performed; when full, no overflow, level unchanged.
//   Pointers wrap modulo DEPTH; rx_level is exact 0..DEPTH.
//  err bits: set by events, cleared by err_clr; set beats clear in the same cycle.
//  res mid-frame or mid-burst: FIFO emptied, FSM to IDLE, err=0; the next falling edge
//   is treated as a start bit.
//  clk0=0: FSM, edge detect and push are frozen; FIFO pop and err_clr still act every clk.
// TESTING
//  1) Frame 0x1C (start0, bits LSB-first, parity0, stop1) -> rx_valid=1, rd_data=8'h1C,
//     level=1, err=0.
//  2) Frame 0x1C with parity=1 -> no push, err=4'b0001; then err_clr -> err=0.
//  3) 9 valid frames 0x01..0x09, DEPTH=8, no rd -> level=8, rx_full=1, err[3]=1;
//     reads return 01..08.
//  4) Stop 4 clock edges into a frame, then TOUT tim_clk pulses -> err[2]=1, FSM IDLE;
//     next full frame 0xF0 is received OK.
//  5) FIFO full; rd coincident with push of 0xAA -> level stays 8, err[3]=0,
//     0xAA is the last entry read.
//  6) Assert res after the 5th data bit -> outputs at reset values; next frame 0x5A
//     received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with a receive FIFO.
//   Synchronises the PS/2 pins and receives 11-bit frames on ps2_clock
//   falling edges. Each frame is start, 8 data bits LSB-first, odd parity
//   and stop. Good bytes go into a first-word-fall-through FIFO. Errors
//   are held in sticky flags.
// Ports:
//   i_clk, i_res                  system clock, synchronous active-high reset
//   i_clk0                        sampling strobe gating all PS/2 logic
//   i_tim_clk                     timeout tick (1-clk pulse)
//   i_ps2_clock, i_ps2_data       asynchronous PS/2 pins
//   i_rd                          pop FIFO head (ignored when empty)
//   o_rd_data, o_rx_valid         FIFO head byte / FIFO not empty
//   o_rx_full, o_rx_level         FIFO full / occupancy 0..DEPTH
//   o_err, i_err_clr              sticky {overflow,timeout,frame,parity} / clear
module ps2_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int TOUT  = 128,
  parameter int SYNC  = 2
) (
  input  logic                       i_clk,
  input  logic                       i_res,
  input  logic                       i_clk0,
  input  logic                       i_tim_clk,
  input  logic                       i_ps2_clock,
  input  logic                       i_ps2_data,
  input  logic                       i_rd,
  output logic [7:0]                 o_rd_data,
  output logic                       o_rx_valid,
  output logic                       o_rx_full,
  output logic [$clog2(DEPTH):0]     o_rx_level,
  output logic [3:0]                 o_err,
  input  logic                       i_err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- synchroniser + edge detect ----------------
  logic [SYNC-1:0] r_sc, r_sd;
  logic            r_sc_prev;
  logic            w_c, w_d, w_fall, w_edge;

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_sc      <= '1;
      r_sd      <= '1;
      r_sc_prev <= 1'b1;
    end else begin
      r_sc <= {r_sc[SYNC-2:0], i_ps2_clock};
      r_sd <= {r_sd[SYNC-2:0], i_ps2_data};
      // The previous-clock sample only advances on strobe cycles.
      // That way an edge is seen exactly once even if it settles between strobes.
      if (i_clk0) r_sc_prev <= r_sc[SYNC-1];
    end
  end

  assign w_c    = r_sc[SYNC-1];
  assign w_d    = r_sd[SYNC-1];
  assign w_fall = i_clk0 & r_sc_prev & ~w_c;
  assign w_edge = i_clk0 & (r_sc_prev ^ w_c);

  // ---------------- frame FSM ----------------
  state_t       r_state, w_state_n;
  logic [2:0]   r_bitcnt, w_bitcnt_n;
  logic [7:0]   r_shift, w_shift_n;
  logic         r_par, w_par_n;
  logic [TW-1:0] r_tcnt;
  logic         w_tout, w_push, w_ferr, w_perr;

  // The tick that would make the counter reach TOUT aborts the frame.
  assign w_tout = (r_state != S_IDLE) && i_tim_clk && !w_edge &&
                  (r_tcnt == TW'(TOUT - 1));

  always_comb begin
    w_state_n  = r_state;
    w_bitcnt_n = r_bitcnt;
    w_shift_n  = r_shift;
    w_par_n    = r_par;
    w_push     = 1'b0;
    w_ferr     = 1'b0;
    w_perr     = 1'b0;
    if (w_tout) begin
      w_state_n = S_IDLE;
    end else if (w_fall) begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_d) begin
            w_state_n  = S_DATA;
            w_bitcnt_n = 3'd0;
          end else begin
            w_ferr = 1'b1;
          end
        end
        S_DATA: begin
          w_shift_n  = {w_d, r_shift[7:1]};
          w_bitcnt_n = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) w_state_n = S_PARITY;
        end
        S_PARITY: begin
          w_par_n   = w_d;
          w_state_n = S_STOP;
        end
        S_STOP: begin
          if (!w_d)                  w_ferr = 1'b1;
          if (!(^{r_shift, r_par}))  w_perr = 1'b1;
          if (w_d && (^{r_shift, r_par})) w_push = 1'b1;
          w_state_n = S_IDLE;
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tcnt   <= '0;
    end else begin
      r_state  <= w_state_n;
      r_bitcnt <= w_bitcnt_n;
      r_shift  <= w_shift_n;
      r_par    <= w_par_n;
      if (r_state == S_IDLE || w_edge || w_tout) r_tcnt <= '0;
      else if (i_tim_clk)                          r_tcnt <= r_tcnt + TW'(1);
    end
  end

  // ---------------- FWFT FIFO ----------------
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [LW-1:0] r_level;
  logic          w_pop, w_full, w_wr, w_ovf;

  assign w_pop  = i_rd && (r_level != '0);
  assign w_full = (r_level == LW'(DEPTH));
  // When full, a simultaneous pop frees the head slot, and wp == rp.
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_ovf  = w_push && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wp] <= r_shift;
  end

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_wr)  r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      unique case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // ---------------- sticky errors ----------------
  logic [3:0] r_err;

  always_ff @(posedge i_clk) begin
    if (i_res) r_err <= '0;
    else       r_err <= (i_err_clr ? 4'b0000 : r_err) | {w_ovf, w_tout, w_ferr, w_perr};
  end

  assign o_rx_valid = (r_level != '0);
  assign o_rx_full  = w_full;
  assign o_rx_level = r_level;
  assign o_rd_data  = o_rx_valid ? r_mem[r_rp] : 8'h00;
  assign o_err      = r_err;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;
  logic       clk = 1'b0;
  logic       res, clk0, tim_clk, ps2_clock, ps2_data, rd, err_clr;
  logic [7:0] rd_data;
  logic       rx_valid, rx_full;
  logic [3:0] rx_level;
  logic [3:0] err;

  bit         c0_auto  = 1'b1;
  bit         c0_force = 1'b0;
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] q[$];

  ps2_rx_fifo #(.DEPTH(8), .TOUT(128), .SYNC(2)) dut (
    .i_clk(clk), .i_res(res), .i_clk0(clk0), .i_tim_clk(tim_clk),
    .i_ps2_clock(ps2_clock), .i_ps2_data(ps2_data), .i_rd(rd),
    .o_rd_data(rd_data), .o_rx_valid(rx_valid), .o_rx_full(rx_full),
    .o_rx_level(rx_level), .o_err(err), .i_err_clr(err_clr)
  );

  always #10 clk = ~clk;

  // Strobe: every other cycle, or forced to a fixed level by the stimulus.
  initial clk0 = 1'b0;
  always @(negedge clk) clk0 = c0_auto ? ~clk0 : c0_force;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit. With sync_stop, the falling edge reaches the DUT on one known strobe cycle.
  // If rd_now is also set, rd is asserted in that same cycle.
  task automatic ps2_bit(input logic b, input bit sync_stop, input bit rd_now);
    ps2_data = b;
    cyc(6);
    if (!sync_stop) begin
      ps2_clock = 1'b0;
      cyc(10);
    end else begin
      c0_auto = 1'b0; c0_force = 1'b0;
      cyc(2);
      ps2_clock = 1'b0;
      cyc(5);
      c0_force = 1'b1; rd = rd_now;
      cyc(1);
      c0_force = 1'b0; rd = 1'b0; c0_auto = 1'b1;
      cyc(4);
    end
    ps2_clock = 1'b1;
    cyc(6);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit badpar);
    logic par;
    par = (~^b) ^ badpar;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit badpar, input bit rd_at_stop);
    logic [10:0] f;
    f = mk_frame(b, badpar);
    for (int i = 0; i < 11; i++) ps2_bit(f[i], (i == 10), rd_at_stop);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [10:0] f;
    f = mk_frame(b, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(f[i], 1'b0, 1'b0);
  endtask

  task automatic do_read();
    rd = 1'b1; cyc(1);
    rd = 1'b0; cyc(1);
  endtask

  task automatic tick();
    tim_clk = 1'b1; cyc(1);
    tim_clk = 1'b0; cyc(1);
  endtask

  task automatic clr_err();
    err_clr = 1'b1; cyc(1);
    err_clr = 1'b0; cyc(1);
  endtask

  initial begin
    res = 1'b1; rd = 1'b0; err_clr = 1'b0; tim_clk = 1'b0;
    ps2_clock = 1'b1; ps2_data = 1'b1;
    // The monitor checks every pop against the expected-byte queue.
    fork
      forever begin
        @(negedge clk);
        if (rd && rx_valid) begin
          if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL pop_unexpected: got %0h expected none", rd_data);
          end else begin
            chk("pop_data", {24'h0, rd_data}, {24'h0, q.pop_front()});
          end
        end
      end
    join_none
    cyc(4);
    res = 1'b0;
    cyc(2);
    chk("rst_valid", {31'h0, rx_valid}, 32'h0);
    chk("rst_full",  {31'h0, rx_full},  32'h0);
    chk("rst_level", {28'h0, rx_level}, 32'h0);
    chk("rst_err",   {28'h0, err},      32'h0);
    chk("rst_data",  {24'h0, rd_data},  32'h0);

    // 1) good frame
    send_frame(8'h1C, 1'b0, 1'b0); q.push_back(8'h1C);
    cyc(2);
    chk("t1_valid", {31'h0, rx_valid}, 32'h1);
    chk("t1_data",  {24'h0, rd_data},  32'h1C);
    chk("t1_level", {28'h0, rx_level}, 32'h1);
    chk("t1_err",   {28'h0, err},      32'h0);
    do_read();
    chk("t1_empty", {28'h0, rx_level}, 32'h0);

    // 2) bad parity
    send_frame(8'h1C, 1'b1, 1'b0);
    cyc(2);
    chk("t2_level", {28'h0, rx_level}, 32'h0);
    chk("t2_err",   {28'h0, err},      32'h1);
    clr_err();
    chk("t2_clr",   {28'h0, err},      32'h0);

    // 3) overflow on the 9th frame
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b0, 1'b0);
      if (i <= 8) q.push_back(8'(i));
    end
    cyc(2);
    chk("t3_level", {28'h0, rx_level}, 32'h8);
    chk("t3_full",  {31'h0, rx_full},  32'h1);
    chk("t3_err",   {28'h0, err},      32'h8);
    for (int i = 0; i < 8; i++) do_read();
    chk("t3_drain", {28'h0, rx_level}, 32'h0);
    clr_err();

    // 4) timeout after four clock edges
    send_partial(8'hF0, 2);
    for (int i = 0; i < 127; i++) tick();
    chk("t4_pre",   {28'h0, err},      32'h0);
    tick();
    chk("t4_tout",  {28'h0, err},      32'h4);
    send_frame(8'hF0, 1'b0, 1'b0); q.push_back(8'hF0);
    cyc(2);
    chk("t4_level", {28'h0, rx_level}, 32'h1);
    chk("t4_err",   {28'h0, err},      32'h4);
    do_read();
    clr_err();

    // 5) full FIFO, pop coincident with push
    for (int i = 0; i < 8; i++) begin
      send_frame(8'h10 + 8'(i), 1'b0, 1'b0); q.push_back(8'h10 + 8'(i));
    end
    chk("t5_full0", {28'h0, rx_level}, 32'h8);
    send_frame(8'hAA, 1'b0, 1'b1); q.push_back(8'hAA);
    cyc(2);
    chk("t5_level", {28'h0, rx_level}, 32'h8);
    chk("t5_err",   {28'h0, err},      32'h0);
    chk("t5_head",  {24'h0, rd_data},  32'h11);
    for (int i = 0; i < 8; i++) do_read();
    chk("t5_drain", {28'h0, rx_level}, 32'h0);

    // 6) reset mid-frame with a byte buffered and an error pending
    send_frame(8'h33, 1'b1, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0);
    chk("t6_pre",   {28'h0, rx_level}, 32'h1);
    send_partial(8'h77, 6);
    res = 1'b1; cyc(1); res = 1'b0; cyc(1);
    chk("t6_level", {28'h0, rx_level}, 32'h0);
    chk("t6_valid", {31'h0, rx_valid}, 32'h0);
    chk("t6_err",   {28'h0, err},      32'h0);
    chk("t6_data",  {24'h0, rd_data},  32'h0);
    cyc(4);
    send_frame(8'h5A, 1'b0, 1'b0); q.push_back(8'h5A);
    cyc(2);
    chk("t6_level2", {28'h0, rx_level}, 32'h1);
    chk("t6_err2",   {28'h0, err},      32'h0);
    do_read();

    cyc(4);
    chk("end_queue", q.size(), 32'h0);
    chk("end_level", {28'h0, rx_level}, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
